i2s_rx: RTL
===========

# i2s_rx

Single-clock I2S receiver: the capture end of the I2S link whose transmitter drives `audio_mclk`/`audio_lrck`/`audio_dac` in the core top level. It oversamples externally supplied SCLK, LRCK and serial data in the system clock domain, deserializes MSB-first words with the standard one-bit I2S delay, and presents parallel stereo sample pairs with a one-cycle valid strobe. It sits between the `audio_adc` pad path and any core logic consuming incoming audio.

## Interface
- `SAMPLE_WIDTH`, 16: bits captured per channel word, MSB first; remaining slot bits are ignored.
- `clk`  input  1  system clock (`clk_74a` domain); must be ≥ 8× SCLK frequency.
- `reset_n`  input  1  synchronous, active-low reset.
- `i2s_sclk`  input  1  bit clock, asynchronous to `clk`.
- `i2s_lrck`  input  1  word select, asynchronous; 0 = left, 1 = right.
- `i2s_sdata`  input  1  serial data, asynchronous; changes on SCLK falling edge.
- `sample_left`  output  SAMPLE_WIDTH  last complete left word.
- `sample_right`  output  SAMPLE_WIDTH  last complete right word.
- `sample_valid`  output  1  one-`clk` pulse when both outputs update together.
- `frame_err`  output  1  one-`clk` pulse on a short word.
- `sample_mono`  output  SAMPLE_WIDTH  mixed mono sample (see Configuration).

## Operation
- Input sync: each of `i2s_sclk`, `i2s_lrck`, `i2s_sdata` passes through a 2-FF synchronizer. `sclk_rise` = synced SCLK high while its previous registered value was low. All capture happens only on `sclk_rise` cycles. LRCK and data are sampled in that cycle.
- `lrck_prev` holds LRCK as sampled at the previous `sclk_rise`. A word start is an `sclk_rise` where sampled LRCK ≠ `lrck_prev`. The bit at that edge is the delay slot and is discarded. The next SAMPLE_WIDTH rising edges shift in MSB..LSB.
- States:
  - WAIT_SYNC: entered at reset. The first `sclk_rise` only loads `lrck_prev`. A later word start goes to SHIFT.
  - SHIFT: `bit_cnt` counts 0..SAMPLE_WIDTH-1. At the SAMPLE_WIDTH-th bit, the word is latched to the channel holding register selected by the word's LRCK, and the state goes to PAD.
  - PAD: remaining bits are ignored until the next word start, which goes to SHIFT.
- Short word: a word start while in SHIFT with fewer than SAMPLE_WIDTH bits pulses `frame_err`. The partial word is discarded, `left_ok` is cleared, and a new word starts normally in SHIFT.
- Pairing:
  - A completed left word sets `left_ok` and stores the word in `left_hold`.
  - A completed right word with `left_ok` set loads `sample_left` ← `left_hold` and `sample_right` ← the new word, pulses `sample_valid`, and clears `left_ok`.
  - A right word without `left_ok` is dropped silently.
- Reset at any point clears all state and discards partial data. Resync requires a fresh LRCK transition.
- Reset values: `sample_left`, `sample_right`, `sample_mono` = 0; `sample_valid`, `frame_err` = 0; state = WAIT_SYNC; `left_ok` = 0.

## Timing
- Latency from the SCLK rising edge at the pad (sampled by `clk`) to `sclk_rise`: 2 `clk`. Outputs and `sample_valid` register on that same edge, so they are visible 3 `clk` after the sampling edge, with ±1 `clk` uncertainty from asynchronous sampling.
- `sample_valid` and `frame_err` are exactly 1 `clk` wide. They are never asserted in the same cycle.
- `sample_left`/`sample_right` are stable between `sample_valid` pulses.
- SCLK high and low phases must each be ≥ 3 `clk`. Behaviour is unspecified otherwise.

## Configuration
- `I2S_RX_MONO_MIX_EN` defined: `sample_mono` is registered in the same cycle as `sample_valid`. Its value is (signed L + signed R) computed at SAMPLE_WIDTH+1 bits, arithmetic-shifted right by 1 (floor), truncated to SAMPLE_WIDTH. No saturation is needed.
- Undefined: `sample_mono` is tied to 0 and the adder is not built.

## Test plan
- Reset, LRCK idle high, then frame L=16'h7000, R=16'h8001, 32-bit slots, SCLK=`clk`/24 → one `sample_valid` pulse with L=7000, R=8001, and no `frame_err`.
- Same frame with random garbage in slot bits 17..31 → outputs identical to the first scenario.
- LRCK toggles after 10 data bits of a left word → one `frame_err` pulse, no `sample_valid` for that pair, and the next full pair L=1234/R=ABCD is delivered.
- `reset_n` low for 2 `clk` mid-right-word after a good left → outputs 0, and no `sample_valid` until a complete new left+right pair.
- Capture starts on a right word (first transition 0→1) → that word is dropped, and the first `sample_valid` comes after the following left+right.
- With the macro: L=7FFE, R=0002 → mono 4000; L=8000, R=8000 → mono 8000; L=FFFF, R=0000 → mono FFFF. Without the macro → mono stays 0.

Source files
------------

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: oversampled SCLK/LRCK/SDATA deserialized into stereo sample pairs
//
// Optional feature macro: I2S_RX_MONO_MIX_EN builds a registered (L+R)/2 mono output.
//
// Ports:
//   clk           system clock (clk_74a domain), at least 8x the bit clock
//   reset_n       synchronous active-low reset
//   i2s_sclk      bit clock, asynchronous to clk
//   i2s_lrck      word select, asynchronous (0 = left, 1 = right)
//   i2s_sdata     serial data, asynchronous, changes on the SCLK falling edge
//   sample_left   last complete left word of a delivered pair
//   sample_right  last complete right word of a delivered pair
//   sample_valid  one-cycle strobe when sample_left/sample_right update together
//   frame_err     one-cycle strobe when a word ends before SAMPLE_WIDTH bits
//   sample_mono   mixed mono sample, tied to 0 when the mix is not built
//
// SAMPLE_WIDTH must be at least 2.

module i2s_rx #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    output logic                    frame_err,
    output logic [SAMPLE_WIDTH-1:0] sample_mono
);

    localparam int CW = $clog2(SAMPLE_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SHIFT,
        PAD
    } state_t;

    // Two-stage synchronizers; all three chains share depth so LRCK and
    // data line up with the SCLK edge they were launched against.
    logic [1:0] sclk_sync;
    logic [1:0] lrck_sync;
    logic [1:0] sdata_sync;
    logic       sclk_d;

    logic sclk_rise;
    logic lrck_s;
    logic sdata_s;
    logic word_start;

    state_t                  state;
    logic                    primed;
    logic                    lrck_prev;
    logic [CW-1:0]           bit_cnt;
    logic [SAMPLE_WIDTH-2:0] shreg;
    logic [SAMPLE_WIDTH-1:0] new_word;
    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic                    left_ok;
    logic                    pair_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            sclk_d     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], i2s_sclk};
            lrck_sync  <= {lrck_sync[0], i2s_lrck};
            sdata_sync <= {sdata_sync[0], i2s_sdata};
            sclk_d     <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign lrck_s    = lrck_sync[1];
    assign sdata_s   = sdata_sync[1];

    // lrck_prev is meaningless until the first rising edge after reset has
    // loaded it, so no word start can be seen before then.
    assign word_start = primed & (lrck_s != lrck_prev);

    // Word as it stands after shifting in the current bit.
    assign new_word = {shreg, sdata_s};

    // A right word completing while a left word is waiting forms a pair.
    assign pair_done = sclk_rise && (state == SHIFT) && !word_start &&
                       (bit_cnt == LAST_BIT) && lrck_s && left_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= WAIT_SYNC;
            primed       <= 1'b0;
            lrck_prev    <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (sclk_rise) begin
                primed    <= 1'b1;
                lrck_prev <= lrck_s;
                case (state)
                    WAIT_SYNC: begin
                        // The edge carrying the LRCK change is the delay slot.
                        if (word_start) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        if (word_start) begin
                            // Short word: drop it and any left word waiting
                            // for its partner, then restart on this edge.
                            frame_err <= 1'b1;
                            left_ok   <= 1'b0;
                            bit_cnt   <= '0;
                        end else begin
                            shreg   <= new_word[SAMPLE_WIDTH-2:0];
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= PAD;
                                if (!lrck_s) begin
                                    left_hold <= new_word;
                                    left_ok   <= 1'b1;
                                end else if (left_ok) begin
                                    sample_left  <= left_hold;
                                    sample_right <= new_word;
                                    sample_valid <= 1'b1;
                                    left_ok      <= 1'b0;
                                end
                                // A right word with no left partner is dropped.
                            end
                        end
                    end
                    PAD: begin
                        if (word_start) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

`ifdef I2S_RX_MONO_MIX_EN
    // One extra bit of headroom makes the sum exact, so halving it can never
    // overflow and no saturation is needed.
    logic signed [SAMPLE_WIDTH:0]   mix_sum;
    logic        [SAMPLE_WIDTH-1:0] mono_q;

    assign mix_sum = $signed({left_hold[SAMPLE_WIDTH-1], left_hold}) +
                     $signed({new_word[SAMPLE_WIDTH-1], new_word});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mono_q <= '0;
        end else if (pair_done) begin
            mono_q <= SAMPLE_WIDTH'(mix_sum >>> 1);
        end
    end

    assign sample_mono = mono_q;
`else
    assign sample_mono = '0;
`endif

endmodule
